// File: rtl/pico_seq_pkg.sv
// pico_seq_pkg: shared state encoding, default timing constants and sizing helper
package pico_seq_pkg;
   typedef enum logic [2:0] {IDLE, PRES_A, PRES_B, RELEASE, CAPTURE, DONE} state_t;
   localparam int NUM_PAIRS_DEF = 4;
   localparam int A_HOLD_DEF = 50;
   localparam int B_HOLD_DEF = 10;
   localparam int SETTLE_DEF = 40;
   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that pulses expire on the last cycle of a phase
module hold_timer #(
   parameter int W = 8
) (
   input  logic         fastclk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] val,
   output logic         expire
);
   logic [W-1:0] cnt;
   always_ff @(posedge fastclk)
      if (reset) cnt <= '0;
      else if (load) cnt <= val;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   assign expire = cnt == W'(1);
endmodule

// File: rtl/pico_sw_sequencer.sv
// pico_sw_sequencer: presents A/B operand pairs to a processor over SW and captures LED results
module pico_sw_sequencer
   import pico_seq_pkg::*;
#(
   parameter int NUM_PAIRS = NUM_PAIRS_DEF,
   parameter int A_HOLD = A_HOLD_DEF,
   parameter int B_HOLD = B_HOLD_DEF,
   parameter int SETTLE = SETTLE_DEF,
   localparam int ADDR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
   input  logic              fastclk,
   input  logic              reset,
   input  logic              start,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   input  logic [7:0]        LED,
   output logic [7:0]        SW,
   output logic              branch_status,
   output logic              res_valid,
   output logic [7:0]        res_data,
   output logic [ADDR_W-1:0] res_idx,
   output logic              busy,
   output logic              done
);
   localparam int TW = $clog2(max3(A_HOLD, B_HOLD, SETTLE) + 1);
   state_t state, nxt;
   logic [ADDR_W-1:0] idx;
   logic [15:0] cur;
   logic [15:0] tbl [2**ADDR_W];
   logic load, expire, last, wr_ok;
   logic [TW-1:0] lval;
   assign last = idx == ADDR_W'(NUM_PAIRS - 1);
   assign wr_ok = state == IDLE && wr_en && 32'(wr_addr) < NUM_PAIRS;
   assign SW = (state == PRES_A) ? cur[15:8] : (state inside {PRES_B, RELEASE, CAPTURE}) ? cur[7:0] : 8'h00;
   assign branch_status = state inside {PRES_A, RELEASE, CAPTURE};
   assign busy = state != IDLE;
   assign done = state == DONE;
   hold_timer #(.W(TW)) u_timer (
      .fastclk(fastclk),
      .reset(reset),
      .load(load),
      .val(lval),
      .expire(expire)
   );
   always_comb begin
      nxt = state;
      load = 1'b0;
      lval = '0;
      case (state)
         IDLE: if (start) begin
            nxt = PRES_A;
            load = 1'b1;
            lval = TW'(A_HOLD);
         end
         PRES_A: if (expire) begin
            nxt = PRES_B;
            load = 1'b1;
            lval = TW'(B_HOLD);
         end
         PRES_B: if (expire) begin
            nxt = RELEASE;
            load = 1'b1;
            lval = TW'(SETTLE);
         end
         RELEASE: if (expire) nxt = CAPTURE;
         CAPTURE: begin
            nxt = last ? DONE : PRES_A;
            load = !last;
            lval = TW'(A_HOLD);
         end
         default: nxt = IDLE;
      endcase
   end
   // the active pair is copied into cur so a write coinciding with start cannot alter the run
   always_ff @(posedge fastclk) begin
      if (reset) begin
         state <= IDLE;
         idx <= '0;
         cur <= '0;
         res_valid <= 1'b0;
         res_data <= '0;
         res_idx <= '0;
         for (int i = 0; i < 2**ADDR_W; i++) tbl[i] <= 16'h0000;
      end else begin
         state <= nxt;
         res_valid <= state == CAPTURE;
         if (state == CAPTURE) begin
            res_data <= LED;
            res_idx <= idx;
         end
         if (state == IDLE && start) begin
            idx <= '0;
            cur <= tbl[0];
         end
         if (state == CAPTURE && !last) begin
            idx <= idx + 1'b1;
            cur <= tbl[idx + 1'b1];
         end
         if (wr_ok) tbl[wr_addr] <= wr_data;
      end
   end
endmodule

// File: tb/tb_pico_sw_sequencer.sv
// tb_pico_sw_sequencer: randomized timeline-model bench for the operand sequencer
module tb_pico_sw_sequencer;
   localparam int A = 50, B = 10, S = 40, N = 4, P = A + B + S + 1;
   localparam int N2 = 3, P2 = 4;
   logic fastclk = 1'b0;
   logic reset, start, wr_en, start2, wr_en2;
   logic [1:0] wr_addr, wr_addr2;
   logic [15:0] wr_data;
   logic [7:0] LED;
   logic [7:0] SW, res_data, SW2, res_data2;
   logic branch_status, res_valid, busy, done;
   logic branch_status2, res_valid2, busy2, done2;
   logic [1:0] res_idx, res_idx2;
   int checks = 0, errors = 0;
   logic [15:0] mdl [N];
   logic [15:0] m2 [N2];
   logic [7:0] hist [0:1023];
   logic [7:0] last_rd;
   logic [1:0] last_ri;

   pico_sw_sequencer dut (
      .fastclk(fastclk), .reset(reset), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .LED(LED), .SW(SW), .branch_status(branch_status),
      .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx), .busy(busy), .done(done)
   );
   pico_sw_sequencer #(.NUM_PAIRS(N2), .A_HOLD(1), .B_HOLD(1), .SETTLE(1)) dut2 (
      .fastclk(fastclk), .reset(reset), .start(start2), .wr_en(wr_en2), .wr_addr(wr_addr2),
      .wr_data(wr_data), .LED(LED), .SW(SW2), .branch_status(branch_status2),
      .res_valid(res_valid2), .res_data(res_data2), .res_idx(res_idx2), .busy(busy2), .done(done2)
   );

   always #5 fastclk = ~fastclk;

   task automatic tick;
      @(negedge fastclk);
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'hffff;
      start2 = 1'b1;
      tick;
      reset = 1'b0; start = 1'b0; wr_en = 1'b0; start2 = 1'b0;
      checks++;
      if ({SW, branch_status, res_valid, res_data, res_idx, busy, done} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs got SW=%h bs=%b rv=%b rd=%h ri=%0d busy=%b done=%b exp all zero",
                  SW, branch_status, res_valid, res_data, res_idx, busy, done);
      end
      checks++;
      if ({SW2, branch_status2, res_valid2, busy2, done2} !== 12'd0) begin
         errors++;
         $display("FAIL reset_outputs2 got SW=%h bs=%b rv=%b busy=%b done=%b exp zero",
                  SW2, branch_status2, res_valid2, busy2, done2);
      end
      last_rd = 8'h00; last_ri = 2'd0;
      for (int i = 0; i < N; i++) mdl[i] = 16'h0000;
   endtask

   task automatic load_table;
      for (int i = 0; i < N; i++) begin
         mdl[i] = 16'($urandom);
         wr_en = 1'b1; wr_addr = 2'(i); wr_data = mdl[i];
         tick;
      end
      wr_en = 1'b0;
      tick;
   endtask

   task automatic test_run(input bit poke_start, input bit poke_wr, input bit wr0);
      logic [15:0] rt [N];
      logic [15:0] nv;
      int nres, ndone;
      rt = mdl; nres = 0; ndone = 0;
      nv = 16'($urandom);
      start = 1'b1;
      if (wr0) begin wr_en = 1'b1; wr_addr = 2'd0; wr_data = nv; end
      tick;
      start = 1'b0; wr_en = 1'b0;
      if (wr0) mdl[0] = nv;
      for (int k = 1; k <= N * P + 4; k++) begin
         int kk, pr, ph;
         logic [7:0] esw;
         logic ebs, erv;
         kk = k - 1; pr = kk / P; ph = kk % P;
         esw = 8'h00; ebs = 1'b0;
         erv = ph == 0 && pr >= 1 && pr <= N;
         if (erv) begin last_rd = hist[k-1]; last_ri = 2'(pr - 1); end
         checks++;
         if (busy !== (kk <= N * P)) begin
            errors++; $display("FAIL busy k=%0d got %b exp %b", kk, busy, kk <= N * P);
         end
         checks++;
         if (done !== (kk == N * P)) begin
            errors++; $display("FAIL done k=%0d got %b exp %b", kk, done, kk == N * P);
         end
         checks++;
         if (res_valid !== erv) begin
            errors++; $display("FAIL res_valid k=%0d got %b exp %b", kk, res_valid, erv);
         end
         checks++;
         if (res_data !== last_rd || res_idx !== last_ri) begin
            errors++;
            $display("FAIL result k=%0d got data=%h idx=%0d exp data=%h idx=%0d", kk, res_data, res_idx, last_rd, last_ri);
         end
         if (pr < N) begin
            esw = (ph < A) ? rt[pr][15:8] : rt[pr][7:0];
            ebs = ph < A || ph >= A + B;
         end
         if (kk != N * P) begin
            checks++;
            if (SW !== esw || branch_status !== ebs) begin
               errors++;
               $display("FAIL sw_bs k=%0d got SW=%h bs=%b exp SW=%h bs=%b", kk, SW, branch_status, esw, ebs);
            end
         end
         nres += int'(res_valid); ndone += int'(done);
         LED = 8'($urandom); hist[k] = LED;
         start = poke_start && kk == P + 20;
         if (poke_wr && kk == 2 * P + 5) begin
            wr_en = 1'b1; wr_addr = 2'd2; wr_data = ~mdl[2];
         end else wr_en = 1'b0;
         tick;
      end
      start = 1'b0; wr_en = 1'b0;
      checks++;
      if (nres != N || ndone != 1) begin
         errors++; $display("FAIL counts got results=%0d dones=%0d exp %0d and 1", nres, ndone, N);
      end
   endtask

   task automatic test_abort;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (2 * P + A + 3) begin LED = 8'($urandom); tick; end
      checks++;
      if (SW !== mdl[2][7:0] || branch_status !== 1'b0) begin
         errors++; $display("FAIL abort_phase got SW=%h bs=%b exp SW=%h bs=0", SW, branch_status, mdl[2][7:0]);
      end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      checks++;
      if ({SW, branch_status, res_valid, res_data, res_idx, busy, done} !== 21'd0) begin
         errors++;
         $display("FAIL abort_outputs got SW=%h bs=%b rv=%b rd=%h ri=%0d busy=%b done=%b exp all zero",
                  SW, branch_status, res_valid, res_data, res_idx, busy, done);
      end
      for (int i = 0; i < N; i++) mdl[i] = 16'h0000;
      last_rd = 8'h00; last_ri = 2'd0;
      repeat (5) begin
         tick;
         checks++;
         if (res_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_quiet got rv=%b done=%b busy=%b exp 0", res_valid, done, busy);
         end
      end
   endtask

   task automatic test_fast;
      logic [7:0] lrd;
      int nres;
      nres = 0; lrd = 8'h00;
      for (int i = 0; i < N2; i++) begin
         m2[i] = 16'($urandom);
         wr_en2 = 1'b1; wr_addr2 = 2'(i); wr_data = m2[i];
         tick;
      end
      wr_en2 = 1'b0;
      start2 = 1'b1;
      tick;
      start2 = 1'b0;
      for (int k = 1; k <= N2 * P2 + 3; k++) begin
         int kk, pr, ph;
         logic erv;
         kk = k - 1; pr = kk / P2; ph = kk % P2;
         erv = ph == 0 && pr >= 1 && pr <= N2;
         if (erv) lrd = hist[k-1];
         checks++;
         if (res_valid2 !== erv || done2 !== (kk == N2 * P2) || busy2 !== (kk <= N2 * P2)) begin
            errors++;
            $display("FAIL fast_ctrl k=%0d got rv=%b done=%b busy=%b exp rv=%b done=%b busy=%b", kk,
                     res_valid2, done2, busy2, erv, kk == N2 * P2, kk <= N2 * P2);
         end
         checks++;
         if (res_data2 !== lrd || (erv && res_idx2 !== 2'(pr - 1))) begin
            errors++; $display("FAIL fast_result k=%0d got data=%h idx=%0d exp data=%h", kk, res_data2, res_idx2, lrd);
         end
         if (pr < N2) begin
            checks++;
            if (SW2 !== ((ph == 0) ? m2[pr][15:8] : m2[pr][7:0]) || branch_status2 !== (ph != 1)) begin
               errors++; $display("FAIL fast_sw_bs k=%0d got SW=%h bs=%b exp SW=%h bs=%b", kk, SW2, branch_status2,
                                  (ph == 0) ? m2[pr][15:8] : m2[pr][7:0], ph != 1);
            end
         end
         nres += int'(res_valid2);
         LED = 8'($urandom); hist[k] = LED;
         tick;
      end
      checks++;
      if (nres != N2) begin
         errors++; $display("FAIL fast_count got %0d exp %0d", nres, N2);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'h0;
      start2 = 1'b0; wr_en2 = 1'b0; wr_addr2 = 2'd0; LED = 8'h00;
      test_reset;
      load_table;
      test_run(1'b0, 1'b0, 1'b0);
      test_run(1'b1, 1'b1, 1'b0);
      test_run(1'b0, 1'b0, 1'b1);
      test_run(1'b0, 1'b0, 1'b0);
      test_abort;
      test_run(1'b0, 1'b0, 1'b0);
      test_fast;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
